gemm_wb_writer: RTL
===================

# gemm_wb_writer

Write-back stage of the GEMM core: the write-side counterpart of the memory read path. Accepts a write-back command (accumulator base index and vector count), then consumes one 16-lane accumulator result vector per valid/ready handshake. Each accepted vector is written to accumulator memory at consecutive indices, and a narrowed copy is written to output memory at the same index. Sits between the GEMM compute array and the accumulator/output SRAMs.

## Interface

Parameters:

- ACC_WIDTH, 32, bits per accumulator lane (signed)
- OUT_WIDTH, 8, bits per output lane (signed)
- LANES, 16, lanes per vector
- ACC_IDX_WIDTH, 12, accumulator/output memory index width
- ACC_MEM_WIDTH, ACC_WIDTH*LANES, accumulator vector width
- OUT_MEM_WIDTH, OUT_WIDTH*LANES, output vector width

Ports:

- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_base  in  ACC_IDX_WIDTH  first write index
- cmd_len  in  ACC_IDX_WIDTH+1  number of vectors (0 allowed)
- res_valid  in  1  result vector present
- res_ready  out  1  result vector accepted when high with res_valid
- res_data  in  ACC_MEM_WIDTH  result vector, lane i at bits [i*ACC_WIDTH +: ACC_WIDTH]
- acc_wr_en  out  1  accumulator memory write strobe
- acc_wr_addr  out  ACC_IDX_WIDTH  accumulator write index
- acc_wr_data  out  ACC_MEM_WIDTH  accumulator write data
- out_wr_en  out  1  output memory write strobe
- out_wr_addr  out  ACC_IDX_WIDTH  output write index
- out_wr_data  out  OUT_MEM_WIDTH  narrowed output data
- done  out  1  one-cycle pulse at command completion

## Operation

- FSM states: IDLE, WRITE, DONE.
- IDLE: cmd_ready=1 and res_ready=0. A cmd handshake latches base into the address counter and len into the remaining counter. The next state is WRITE if len≠0, otherwise DONE.
- WRITE: cmd_ready=0 and res_ready=1. Each res handshake registers the write:
  - acc_wr_data=res_data and out_wr_data=narrow(res_data)
  - addr = current counter value
  - the counter increments and remaining decrements
- The handshake that brings remaining to 0 moves the FSM to DONE. res_valid low in WRITE leaves the FSM in WRITE and writes nothing.
- DONE: done=1 and both ready signals are 0. The FSM returns to IDLE after one cycle.
- Address arithmetic is modulo 2^ACC_IDX_WIDTH. Base 0xFFF with len 2 writes 0xFFF then 0x000.
- acc_wr_en and out_wr_en are always equal. Both addresses are always equal.
- Narrowing is lane-wise. The default is truncation: keep the low OUT_WIDTH bits of each lane (see Configuration).
- res_data presented outside WRITE is ignored (res_ready=0).

## Timing

- All outputs are registered.
- Reset values: cmd_ready=0, res_ready=0, done=0, both write enables 0, all addresses 0, all data 0, FSM=IDLE.
- cmd_ready rises the first cycle after reset deasserts.
- Write latency is 1 cycle: a res handshake at edge t drives the write strobe/addr/data during cycle t+1. Enables are high for exactly one cycle per accepted vector.
- With back-to-back res_valid, throughput is 1 vector/cycle.
- len≠0: done asserts in the same cycle as the last write strobe.
- len=0: done asserts the cycle after the cmd handshake, with no write strobes.
- The next command is accepted no earlier than the cycle after done.
- Reset mid-operation: everything returns to reset values immediately (asynchronously). The command is abandoned with no done pulse and no further writes.

## Configuration

- GEMM_WB_SAT_EN defined: narrowing saturates each signed lane to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1]. For OUT_WIDTH=8 that is [-128, 127].
- Not defined: narrowing truncates each lane to its low OUT_WIDTH bits.
- acc_wr_data is the unmodified result in both cases.

## Test plan

- Reset/idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Release -> cmd_ready=1 one cycle later, with no writes while idle.
- Basic burst: cmd base=0x010, len=4, res_valid held high with vectors V0..V3 -> four consecutive strobes at addresses 0x010..0x013 carrying V0..V3, done coincident with the 0x013 write, cmd_ready back high the following cycle.
- Stalls and wrap: base=0xFFE, len=3, res_valid toggled 1,0,0,1,1 -> writes at 0xFFE, 0xFFF, 0x000 only on handshake cycles+1, and no strobe during gaps.
- Zero length: cmd len=0 -> done one cycle after the handshake, no write strobes, res_ready never high.
- Narrowing: lane values 0x0000_0105, 0xFFFF_FF00, 0x0000_007F -> out lanes 0x05, 0x00, 0x7F without GEMM_WB_SAT_EN, and 0x7F, 0x80, 0x7F with it. acc lanes are unchanged in both builds.
- Abort: reset asserted after 2 of 5 beats -> no further strobes, no done. A new command after reset runs normally from its own base.

Source files
------------

// File: rtl/gemm_wb_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gemm_wb_writer
// Brief    : GEMM write-back stage; writes result vectors to accumulator and
//            narrowed output memories. GEMM_WB_SAT_EN selects saturating narrowing.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_wb_writer #(
    parameter int ACC_WIDTH     = 32,
    parameter int OUT_WIDTH     = 8,
    parameter int LANES         = 16,
    parameter int ACC_IDX_WIDTH = 12,
    parameter int ACC_MEM_WIDTH = ACC_WIDTH * LANES,
    parameter int OUT_MEM_WIDTH = OUT_WIDTH * LANES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ACC_IDX_WIDTH-1:0] cmd_base,
    input  logic [ACC_IDX_WIDTH:0]   cmd_len,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [ACC_MEM_WIDTH-1:0] res_data,
    output logic                     acc_wr_en,
    output logic [ACC_IDX_WIDTH-1:0] acc_wr_addr,
    output logic [ACC_MEM_WIDTH-1:0] acc_wr_data,
    output logic                     out_wr_en,
    output logic [ACC_IDX_WIDTH-1:0] out_wr_addr,
    output logic [OUT_MEM_WIDTH-1:0] out_wr_data,
    output logic                     done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [ACC_IDX_WIDTH-1:0] r_addr;
    logic [ACC_IDX_WIDTH:0]   r_remaining;
    logic [OUT_MEM_WIDTH-1:0] w_narrow;
    logic                     w_cmd_hs;
    logic                     w_res_hs;

    assign w_cmd_hs = cmd_valid & cmd_ready;
    assign w_res_hs = res_valid & res_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_cmd_hs) w_next = (cmd_len != '0) ? ST_WRITE : ST_DONE;
            ST_WRITE: if (w_res_hs && (r_remaining == (ACC_IDX_WIDTH+1)'(1))) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Ready/done are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b0;
            res_ready <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_next;
            cmd_ready <= (w_next == ST_IDLE);
            res_ready <= (w_next == ST_WRITE);
            done      <= (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            acc_wr_en   <= 1'b0;
            out_wr_en   <= 1'b0;
            acc_wr_addr <= '0;
            out_wr_addr <= '0;
            acc_wr_data <= '0;
            out_wr_data <= '0;
        end else begin
            acc_wr_en <= w_res_hs;
            out_wr_en <= w_res_hs;
            if (w_cmd_hs) begin
                r_addr      <= cmd_base;
                r_remaining <= cmd_len;
            end else if (w_res_hs) begin
                r_addr      <= r_addr + ACC_IDX_WIDTH'(1);
                r_remaining <= r_remaining - (ACC_IDX_WIDTH+1)'(1);
            end
            if (w_res_hs) begin
                acc_wr_addr <= r_addr;
                out_wr_addr <= r_addr;
                acc_wr_data <= res_data;
                out_wr_data <= w_narrow;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef GEMM_WB_SAT_EN
        localparam logic signed [ACC_WIDTH-1:0] c_max =
            {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        localparam logic signed [ACC_WIDTH-1:0] c_min =
            {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
        logic signed [ACC_WIDTH-1:0] w_lane;
        assign w_lane = res_data[gi*ACC_WIDTH +: ACC_WIDTH];
        assign w_narrow[gi*OUT_WIDTH +: OUT_WIDTH] =
            (w_lane > c_max) ? c_max[OUT_WIDTH-1:0] :
            (w_lane < c_min) ? c_min[OUT_WIDTH-1:0] :
                               w_lane[OUT_WIDTH-1:0];
`else
        assign w_narrow[gi*OUT_WIDTH +: OUT_WIDTH] = res_data[gi*ACC_WIDTH +: OUT_WIDTH];
`endif
    end

endmodule
`default_nettype wire
